// File: rtl/shift_add_mult_ctrl_if.sv
// shift_add_mult_ctrl_if: request/result bundle between the multiplier top and its controller
interface shift_add_mult_ctrl_if #(parameter int N = 8);
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  modport master (output start, multiplicand, multiplier, input busy, done, product);
  modport slave  (input start, multiplicand, multiplier, output busy, done, product);
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: shift-add multiplier FSM time-sharing one external N-bit adder
module shift_add_mult_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_add_mult_ctrl_if.slave bus,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_cin,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [N-1:0]     r_a, r_q, r_m;
  logic [CNT_W-1:0] r_cnt;
  logic [2*N-1:0]   r_product;
  logic             w_load, w_last;
  assign add_a       = r_a;
  assign add_b       = r_q[0] ? r_m : '0;
  assign add_cin     = 1'b0;
  assign bus.busy    = r_state == RUN;
  assign bus.done    = r_state == DONE;
  assign bus.product = r_product;
  // next state: start is only honoured outside RUN, which also gives back-to-back reloads from DONE
  always_comb begin
    w_load = bus.start && r_state != RUN;
    w_last = r_state == RUN && r_cnt == CNT_W'(N - 1);
    w_next = w_load ? RUN : w_last ? DONE : r_state == RUN ? RUN : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // datapath: load operands, shift the {A,Q} pair right through the adder, capture the final step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_load) begin
      r_a   <= '0;
      r_q   <= bus.multiplier;
      r_m   <= bus.multiplicand;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= {add_cout, add_sum[N-1:1]};
      r_q   <= {add_sum[0], r_q[N-1:1]};
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_product <= {add_cout, add_sum, r_q[N-1:1]};
    end
  end
endmodule
